srt_rx_buffer: RTL and testbench
================================

Name: srt_rx_buffer

Overview:
Receive-side byte buffer placed directly downstream of the serial reception system, replacing its standalone ACK generator. Captures each received byte and its error flag on the receiver's data-ready strobe and returns the acknowledge. Stores captured bytes in a FIFO and presents them to the consumer over a valid/ready interface. Keeps occupancy and error statistics for the top design.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
AW, 3, pointer width, log2(DEPTH)
ACK_CYCLES, 1, cycles ack is held high per captured byte (1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
dry  in  1  receiver data-ready, level; held high until ack seen
q_in  in  8  received byte, stable while dry high
err_in  in  1  receiver error flag for q_in, stable while dry high
ack  out  1  acknowledge to receiver
rd_valid  out  1  head entry available
rd_ready  in  1  consumer accepts head entry
rd_data  out  8  head byte
rd_err  out  1  error flag stored with head byte
count  out  AW+1  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
err_cnt  out  8  saturating count of captured bytes with err_in=1
overflow  out  1  sticky; set when a byte is dropped (feature only), else constant 0

Behaviour:
- Reset (rst=0 at clk edge): pointers, count=0, empty=1, full=0, ack=0, err_cnt=0, overflow=0, FSM=IDLE. rd_data/rd_err don't-care while empty.
- Capture FSM, states IDLE, ACK, WAIT_LOW:
  - IDLE: dry=1 and full=0 -> write {err_in,q_in} at write pointer, FSM->ACK, ack=1 from the next cycle. dry=1 and full=1 -> stay IDLE, ack=0 (backpressure; receiver stalls).
  - ACK: ack held high exactly ACK_CYCLES cycles, then FSM->WAIT_LOW, ack=0.
  - WAIT_LOW: stay until dry=0, then ->IDLE. Guarantees one capture per dry assertion, even if dry is held for many cycles.
- Capture latency: dry rising sampled at edge N -> entry written and ack=1 after edge N; rd_valid=1 after edge N if the FIFO was empty.
- Full is evaluated from registered count. A pop in the same cycle as a full-blocked capture does not admit the write; the write occurs at the next edge.
- Read: rd_valid = ~empty; rd_data/rd_err show head combinationally (first-word fall-through). Pop on rd_valid & rd_ready; rd_ready ignored when empty.
- Simultaneous write and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count is AW+1 bits so full and empty are unambiguous.
- err_cnt increments on each capture with err_in=1; saturates at 255.
- Reset mid-handshake: FSM returns to IDLE and ack drops. If dry is still high after reset release, the byte is captured again, because the receiver never saw a completed ack.

Optional Feature:
SRT_RXBUF_DROP_ON_FULL_EN
- Defined: in IDLE with dry=1 and full=1, the byte is discarded and the FSM still runs ACK->WAIT_LOW (receiver never stalls). overflow is set and stays set until reset. FIFO contents and err_cnt are unchanged.
- Undefined: backpressure as above; overflow tied to 0.

Decomposition:
- Package srt_pkg: FSM state encoding (IDLE, ACK, WAIT_LOW), BYTE_W=8, entry width BYTE_W+1, ERRCNT_W=8.
- Sub-module srt_fifo_mem: DEPTH x 9 register array with write port and asynchronous read port, no control logic.
- Pointers, count and FSM live in srt_rx_buffer.

Test Plan:
- Reset then dry=1, q_in=8'hA5, err_in=0 -> ack high 1 cycle after edge; rd_valid=1, rd_data=A5, count=1. dry held 10 cycles -> count stays 1.
- 8 bytes 01..08, no reads -> full=1, count=8. 9th dry -> ack stays 0. Pop one (rd_data=01) -> 9th byte captured next cycle, full=1 again.
- Continuous rd_ready=1 with back-to-back bytes 10..1F -> output order 10..1F, count never exceeds 1, pointers wrap twice.
- 3 bytes with err_in=1, then 300 error bytes with reads enabled -> rd_err matches per entry; err_cnt=3 then saturates at 255.
- rst=0 asserted during ACK state with dry=1 -> ack=0, count=0. After release with dry=1 -> byte recaptured, count=1.
- SRT_RXBUF_DROP_ON_FULL_EN defined, FIFO full, dry with 8'hEE -> ack pulses, overflow=1, count=8, EE never appears on rd_data.

Source files
------------

// File: rtl/srt_pkg.sv
// Shared types and widths for the serial receive buffer (srt_rx_buffer).
package srt_pkg;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned ENTRY_W  = BYTE_W + 1;
  localparam int unsigned ERRCNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_WAIT_LOW
  } cap_state_t;

  typedef logic [ENTRY_W-1:0] entry_t;
endpackage

// File: rtl/srt_fifo_mem.sv
// Register-array storage for the receive FIFO: one write port, asynchronous read port.
module srt_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned W     = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/srt_rx_buffer.sv
// Receive-side byte buffer: capture FSM with ack handshake, FIFO, occupancy and error stats.
// Optional build macro SRT_RXBUF_DROP_ON_FULL_EN: drop bytes on full instead of stalling.
module srt_rx_buffer
  import srt_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AW         = 3,
  parameter int unsigned ACK_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dry,
  input  logic [BYTE_W-1:0]   q_in,
  input  logic                err_in,
  output logic                ack,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [BYTE_W-1:0]   rd_data,
  output logic                rd_err,
  output logic [AW:0]         count,
  output logic                full,
  output logic                empty,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic                overflow
);
  localparam logic [AW:0]         FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]         CNT_ONE  = 1;
  localparam logic [AW-1:0]       PTR_ONE  = 1;
  localparam logic [ERRCNT_W-1:0] ERR_ONE  = 1;
  localparam logic [3:0]          ACK_LAST = 4'(ACK_CYCLES - 1);

  cap_state_t      state, state_nxt;
  logic [3:0]      ack_cnt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     cnt_q;
  logic [ERRCNT_W-1:0] err_q;
  logic            do_write, do_pop, drop;
  entry_t          head;

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign rd_valid = ~empty;
  assign do_pop   = ~empty & rd_ready;
  assign ack      = (state == ST_ACK);
  assign err_cnt  = err_q;
  assign rd_data  = head[BYTE_W-1:0];
  assign rd_err   = head[BYTE_W];

  // Full comes from the registered count, so a same-cycle pop never admits a blocked write.
  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    drop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dry) begin
          if (!full) begin
            do_write  = 1'b1;
            state_nxt = ST_ACK;
          end else begin
`ifdef SRT_RXBUF_DROP_ON_FULL_EN
            drop      = 1'b1;
            state_nxt = ST_ACK;
`else
            drop      = 1'b0;
`endif
          end
        end
      end
      ST_ACK:      if (ack_cnt == ACK_LAST) state_nxt = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!dry) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      ack_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state   <= state_nxt;
      ack_cnt <= (state == ST_ACK) ? ack_cnt + 4'd1 : '0;
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_write, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
      if (do_write && err_in && (err_q != '1)) err_q <= err_q + ERR_ONE;
    end
  end

`ifdef SRT_RXBUF_DROP_ON_FULL_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (!rst)      ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end
  assign overflow = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign overflow    = 1'b0;
`endif

  srt_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata ({err_in, q_in}),
    .raddr (rd_ptr),
    .rdata (head)
  );
endmodule

// File: tb/tb_srt_rx_buffer.sv
// Directed self-checking bench for srt_rx_buffer (default parameters).
module tb_srt_rx_buffer;
  logic       clk = 1'b0;
  logic       rst;
  logic       dry;
  logic [7:0] q_in;
  logic       err_in;
  logic       ack;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_err;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic [7:0] err_cnt;
  logic       overflow;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic        mon_en = 1'b0;
  logic [3:0]  max_cnt = '0;

  always #5 clk = ~clk;

  srt_rx_buffer #(
    .DEPTH      (8),
    .AW         (3),
    .ACK_CYCLES (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dry      (dry),
    .q_in     (q_in),
    .err_in   (err_in),
    .ack      (ack),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .err_cnt  (err_cnt),
    .overflow (overflow)
  );

  always @(negedge clk) begin
    if (mon_en && (count > max_cnt)) max_cnt = count;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receiver model: hold dry until ack, drop it, then allow WAIT_LOW to return to IDLE.
  task automatic send_byte(input logic [7:0] d, input logic e, input bit check_head);
    int unsigned n;
    q_in = d; err_in = e; dry = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ack && n < 20);
    if (!ack) chk("ack_timeout", {31'd0, ack}, 32'd1);
    else if (check_head) begin
      chk("head_data", {24'd0, rd_data}, {24'd0, d});
      chk("head_err", {31'd0, rd_err}, {31'd0, e});
    end
    dry = 1'b0;
    n = 0;
    while (ack && n < 20) begin tick(); n++; end
    tick();
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d);
    chk(tag, {24'd0, rd_data}, {24'd0, d});
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; dry = 1'b0; q_in = '0; err_in = 1'b0; rd_ready = 1'b0;
    repeat (3) tick();
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b1;
    tick();

    // First capture and one-capture-per-dry with dry held
    dry = 1'b1; q_in = 8'hA5; err_in = 1'b0;
    tick();
    chk("cap_ack", {31'd0, ack}, 32'd1);
    chk("cap_valid", {31'd0, rd_valid}, 32'd1);
    chk("cap_data", {24'd0, rd_data}, 32'hA5);
    chk("cap_count", {28'd0, count}, 32'd1);
    tick();
    chk("ack_len", {31'd0, ack}, 32'd0);
    repeat (10) tick();
    chk("hold_count", {28'd0, count}, 32'd1);
    dry = 1'b0;
    tick();
    pop_check("pop_a5", 8'hA5);
    chk("pop_empty", {31'd0, empty}, 32'd1);

    // Fill to full
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0, 1'b0);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_count", {28'd0, count}, 32'd8);
`ifdef SRT_RXBUF_DROP_ON_FULL_EN
    dry = 1'b1; q_in = 8'hEE;
    tick();
    chk("drop_ack", {31'd0, ack}, 32'd1);
    chk("drop_ovf", {31'd0, overflow}, 32'd1);
    chk("drop_count", {28'd0, count}, 32'd8);
    dry = 1'b0;
    tick(); tick();
    for (int i = 1; i <= 8; i++) pop_check("drop_drain", 8'(i));
    chk("drop_empty", {31'd0, empty}, 32'd1);
`else
    dry = 1'b1; q_in = 8'h09;
    repeat (3) tick();
    chk("bp_ack", {31'd0, ack}, 32'd0);
    chk("bp_count", {28'd0, count}, 32'd8);
    chk("bp_ovf", {31'd0, overflow}, 32'd0);
    chk("bp_head", {24'd0, rd_data}, 32'h01);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("bp_pop_ack", {31'd0, ack}, 32'd0);
    chk("bp_pop_count", {28'd0, count}, 32'd7);
    tick();
    chk("bp_late_ack", {31'd0, ack}, 32'd1);
    chk("bp_late_full", {31'd0, full}, 32'd1);
    dry = 1'b0;
    tick(); tick();
    for (int i = 2; i <= 9; i++) pop_check("bp_drain", 8'(i));
    chk("bp_empty", {31'd0, empty}, 32'd1);
`endif

    // Streaming with consumer always ready; 16 bytes wrap the pointers twice
    rd_ready = 1'b1;
    max_cnt = '0;
    mon_en = 1'b1;
    for (int i = 16; i <= 31; i++) send_byte(8'(i), 1'b0, 1'b1);
    mon_en = 1'b0;
    chk("stream_max", {28'd0, max_cnt}, 32'd1);
    chk("stream_count", {28'd0, count}, 32'd0);

    // Error flags and saturation
    for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i), 1'b1, 1'b1);
    chk("errcnt_3", {24'd0, err_cnt}, 32'd3);
    send_byte(8'h55, 1'b0, 1'b1);
    chk("errcnt_clean", {24'd0, err_cnt}, 32'd3);
    for (int i = 0; i < 300; i++) send_byte(8'(i), 1'b1, (i % 50) == 0);
    chk("errcnt_sat", {24'd0, err_cnt}, 32'd255);
    rd_ready = 1'b0;

    // Reset during ACK with dry still high
    dry = 1'b1; q_in = 8'hC3; err_in = 1'b0;
    tick();
    chk("mid_ack", {31'd0, ack}, 32'd1);
    rst = 1'b0;
    tick();
    chk("mid_rst_ack", {31'd0, ack}, 32'd0);
    chk("mid_rst_count", {28'd0, count}, 32'd0);
    chk("mid_rst_errcnt", {24'd0, err_cnt}, 32'd0);
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b1;
    tick();
    chk("recap_ack", {31'd0, ack}, 32'd1);
    chk("recap_count", {28'd0, count}, 32'd1);
    chk("recap_data", {24'd0, rd_data}, 32'hC3);
    dry = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
